// File: rtl/cp0_exception.sv
// cp0_exception: coprocessor-0 register file and precise-exception controller.
// Picks at most one exception per cycle for the MEM-stage instruction, raises
// flush with the redirect PC, and maintains Status, Cause, EPC, BadVAddr,
// Count and Compare.
// Optional feature: define CP0_TIMER_INT_EN to let Count==Compare raise a
// sticky timer interrupt on Cause.IP[7]; without it the timer flag is tied low.
module cp0_exception #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          HW_INT_W   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    input  logic [31:0]         mem_pc,
    input  logic                mem_in_delay,
    input  logic                mem_break,
    input  logic                mem_syscall,
    input  logic                mem_eret,
    input  logic                mem_reserve,
    input  logic                mem_overflow,
    input  logic                mem_adel_if,
    input  logic                mem_adel,
    input  logic                mem_ades,
    input  logic [31:0]         mem_bad_addr,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic                cp0_we,
    input  logic [4:0]          cp0_waddr,
    input  logic [4:0]          cp0_raddr,
    input  logic [31:0]         cp0_wdata,
    output logic [31:0]         cp0_rdata,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic [4:0]          exc_code,
    output logic [31:0]         status_o,
    output logic [31:0]         cause_o,
    output logic [31:0]         epc_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_ERET = 5'h1f;

    // Only six interrupt lines exist in Cause.IP[7:2]; extra lines are ignored.
    localparam int HW_N = (HW_INT_W < 6) ? HW_INT_W : 6;

    // Architectural state, kept as fields and packed into words on output.
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [31:0] bad_vaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        count_toggle;
    logic        timer_flag;

    logic [5:0]  hw_lines;
    logic        int_pending;
    logic        take_exc;
    logic        take_eret;
    logic [4:0]  code;
    logic        bad_en;
    logic [31:0] bad_val;
    logic        wr_en;

    assign status_o = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_o  = {cause_bd, 15'b0, cause_ip, 1'b0, cause_exc, 2'b0};
    assign epc_o    = epc;

    // Normalise the external interrupt vector to the six IP[7:2] lines.
    always_comb begin
        hw_lines            = '0;
        hw_lines[HW_N-1:0]  = hw_int[HW_N-1:0];
    end

    // Prioritised exception detection for the MEM-stage instruction.
    always_comb begin
        int_pending = status_ie && !status_exl &&
                      ((cause_ip[7:2] & status_im[7:2]) != 6'b0);
        take_exc  = 1'b0;
        take_eret = 1'b0;
        code      = EXC_INT;
        bad_en    = 1'b0;
        bad_val   = 32'b0;
        if (mem_valid && !rst) begin
            if (int_pending) begin
                take_exc = 1'b1;
                code     = EXC_INT;
            end else if (mem_adel_if) begin
                take_exc = 1'b1;
                code     = EXC_ADEL;
                bad_en   = 1'b1;
                bad_val  = mem_pc;
            end else if (mem_reserve) begin
                take_exc = 1'b1;
                code     = EXC_RI;
            end else if (mem_syscall) begin
                take_exc = 1'b1;
                code     = EXC_SYS;
            end else if (mem_break) begin
                take_exc = 1'b1;
                code     = EXC_BP;
            end else if (mem_overflow) begin
                take_exc = 1'b1;
                code     = EXC_OV;
            end else if (mem_adel) begin
                take_exc = 1'b1;
                code     = EXC_ADEL;
                bad_en   = 1'b1;
                bad_val  = mem_bad_addr;
            end else if (mem_ades) begin
                take_exc = 1'b1;
                code     = EXC_ADES;
                bad_en   = 1'b1;
                bad_val  = mem_bad_addr;
            end else if (mem_eret) begin
                take_eret = 1'b1;
            end
        end
    end

    // Redirect outputs and the mtc0 gate (a flushing cycle drops the write).
    always_comb begin
        flush    = take_exc || take_eret;
        new_pc   = take_exc ? EXC_VECTOR : (take_eret ? epc : 32'b0);
        exc_code = take_exc ? code : (take_eret ? EXC_ERET : 5'b0);
        wr_en    = cp0_we && !flush;
    end

    // Status: EXL set on exception, cleared on eret, otherwise mtc0-writable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_im  <= 8'b0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else if (take_exc) begin
            status_exl <= 1'b1;
        end else if (take_eret) begin
            status_exl <= 1'b0;
        end else if (wr_en && cp0_waddr == REG_STATUS) begin
            status_im  <= cp0_wdata[15:8];
            status_exl <= cp0_wdata[1];
            status_ie  <= cp0_wdata[0];
        end
    end

    // Cause: hardware IP sampled every cycle; BD/ExcCode on exception; IP[1:0] by mtc0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_bd  <= 1'b0;
            cause_ip  <= 8'b0;
            cause_exc <= 5'b0;
        end else begin
            cause_ip[7:2] <= {hw_lines[5] | timer_flag, hw_lines[4:0]};
            if (take_exc) begin
                cause_bd  <= mem_in_delay;
                cause_exc <= code;
            end else if (wr_en && cp0_waddr == REG_CAUSE) begin
                cause_ip[1:0] <= cp0_wdata[9:8];
            end
        end
    end

    // EPC: captured on the first exception (EXL clear), else mtc0-writable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc <= 32'b0;
        end else if (take_exc) begin
            if (!status_exl) begin
                epc <= mem_in_delay ? (mem_pc - 32'd4) : mem_pc;
            end
        end else if (wr_en && cp0_waddr == REG_EPC) begin
            epc <= cp0_wdata;
        end
    end

    // BadVAddr: loaded only by address-error exceptions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_vaddr <= 32'b0;
        end else if (take_exc && bad_en) begin
            bad_vaddr <= bad_val;
        end
    end

    // Count: +1 every second cycle; an mtc0 write takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_toggle <= 1'b0;
            count        <= 32'b0;
        end else begin
            count_toggle <= !count_toggle;
            if (wr_en && cp0_waddr == REG_COUNT) begin
                count <= cp0_wdata;
            end else if (count_toggle) begin
                count <= count + 32'd1;
            end
        end
    end

    // Compare: plain mtc0-writable register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare <= 32'b0;
        end else if (wr_en && cp0_waddr == REG_COMPARE) begin
            compare <= cp0_wdata;
        end
    end

`ifdef CP0_TIMER_INT_EN
    // Timer flag: sticky on Count==Compare (Compare nonzero), cleared by writing Compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_flag <= 1'b0;
        end else if (wr_en && cp0_waddr == REG_COMPARE) begin
            timer_flag <= 1'b0;
        end else if (count == compare && compare != 32'b0) begin
            timer_flag <= 1'b1;
        end
    end
`else
    assign timer_flag = 1'b0;
`endif

    // mfc0 read port straight from current register state.
    always_comb begin
        case (cp0_raddr)
            REG_BADVADDR: cp0_rdata = bad_vaddr;
            REG_COUNT:    cp0_rdata = count;
            REG_COMPARE:  cp0_rdata = compare;
            REG_STATUS:   cp0_rdata = status_o;
            REG_CAUSE:    cp0_rdata = cause_o;
            REG_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = 32'b0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exception.sv
// tb_cp0_exception: directed scenarios plus randomized traffic for cp0_exception,
// compared every cycle against a word-level model of the CP0 registers.
module tb_cp0_exception;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [4:0]  CODES [8] = '{5'h00, 5'h04, 5'h0a, 5'h08, 5'h09, 5'h0c, 5'h04, 5'h05};
  localparam logic [4:0]  REGS  [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid, mem_in_delay;
  logic        mem_break, mem_syscall, mem_eret, mem_reserve, mem_overflow;
  logic        mem_adel_if, mem_adel, mem_ades;
  logic [31:0] mem_pc, mem_bad_addr;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_waddr, cp0_raddr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata, new_pc, status_o, cause_o, epc_o;
  logic        flush;
  logic [4:0]  exc_code;

  always #5 clk = ~clk;

  cp0_exception #(.EXC_VECTOR(EXC_VECTOR), .HW_INT_W(6)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_in_delay(mem_in_delay),
    .mem_break(mem_break), .mem_syscall(mem_syscall), .mem_eret(mem_eret),
    .mem_reserve(mem_reserve), .mem_overflow(mem_overflow),
    .mem_adel_if(mem_adel_if), .mem_adel(mem_adel), .mem_ades(mem_ades),
    .mem_bad_addr(mem_bad_addr), .hw_int(hw_int),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_raddr(cp0_raddr),
    .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .flush(flush), .new_pc(new_pc), .exc_code(exc_code),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  // ---------------- scoreboard counters / checker ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare;
  logic        m_timer;
  int          m_edges;

  logic        e_flush, e_exc, e_bad_en;
  logic [31:0] e_pc, e_bad;
  logic [4:0]  e_code;

  function automatic void model_reset();
    m_status  = 32'h0040_0000;
    m_cause   = 32'b0;
    m_epc     = 32'b0;
    m_bad     = 32'b0;
    m_count   = 32'b0;
    m_compare = 32'b0;
    m_timer   = 1'b0;
    m_edges   = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'b0;
    endcase
  endfunction

  // Pick the first raised request from the priority table.
  function automatic void model_decide();
    logic [7:0] req;
    logic       intp;
    e_flush = 1'b0; e_exc = 1'b0; e_bad_en = 1'b0;
    e_pc = 32'b0; e_bad = 32'b0; e_code = 5'b0;
    if (rst || !mem_valid) return;
    intp = m_status[0] && !m_status[1] && ((m_cause[15:10] & m_status[15:10]) != 6'b0);
    req = {mem_ades, mem_adel, mem_overflow, mem_break, mem_syscall, mem_reserve, mem_adel_if, intp};
    for (int i = 0; i < 8; i++) begin
      if (req[i] && !e_exc) begin
        e_exc   = 1'b1;
        e_flush = 1'b1;
        e_pc    = EXC_VECTOR;
        e_code  = CODES[i];
        if (i == 1) begin e_bad_en = 1'b1; e_bad = mem_pc; end
        if (i >= 6) begin e_bad_en = 1'b1; e_bad = mem_bad_addr; end
      end
    end
    if (!e_exc && mem_eret) begin
      e_flush = 1'b1;
      e_pc    = m_epc;
      e_code  = 5'h1f;
    end
  endfunction

  // Advance the model by one clock edge using the current inputs.
  function automatic void model_step();
    logic        wr;
    logic        old_exl, old_timer;
    logic [31:0] old_count, old_compare;
    wr          = cp0_we && !e_flush;
    old_exl     = m_status[1];
    old_timer   = m_timer;
    old_count   = m_count;
    old_compare = m_compare;
    m_edges++;
`ifdef CP0_TIMER_INT_EN
    if (wr && cp0_waddr == 5'd11) m_timer = 1'b0;
    else if (old_count == old_compare && old_compare != 0) m_timer = 1'b1;
`endif
    if (wr && cp0_waddr == 5'd9) m_count = cp0_wdata;
    else if (m_edges % 2 == 0) m_count = old_count + 1;
    if (wr && cp0_waddr == 5'd11) m_compare = cp0_wdata;
    m_cause[15:10] = {hw_int[5] | old_timer, hw_int[4:0]};
    if (e_exc) begin
      m_status[1]   = 1'b1;
      m_cause[31]   = mem_in_delay;
      m_cause[6:2]  = e_code;
      if (!old_exl) m_epc = mem_in_delay ? mem_pc - 32'd4 : mem_pc;
      if (e_bad_en) m_bad = e_bad;
    end else if (e_flush) begin
      m_status[1] = 1'b0;
    end else if (wr) begin
      case (cp0_waddr)
        5'd12: m_status = (m_status & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
        5'd13: m_cause  = (m_cause & ~CAUSE_WMASK) | (cp0_wdata & CAUSE_WMASK);
        5'd14: m_epc    = cp0_wdata;
        default: ;
      endcase
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    mem_valid = 0; mem_pc = 0; mem_in_delay = 0;
    mem_break = 0; mem_syscall = 0; mem_eret = 0; mem_reserve = 0; mem_overflow = 0;
    mem_adel_if = 0; mem_adel = 0; mem_ades = 0; mem_bad_addr = 0;
    hw_int = 0; cp0_we = 0; cp0_waddr = 0; cp0_raddr = 0; cp0_wdata = 0;
  endtask

  function automatic logic [4:0] pick_reg();
    int s;
    s = $urandom_range(0, 6);
    if (s == 6) return 5'($urandom());
    return REGS[s];
  endfunction

  task automatic drive_random();
    mem_valid    = ($urandom_range(0, 3) != 0);
    mem_pc       = $urandom() & 32'hFFFF_FFFC;
    mem_in_delay = $urandom_range(0, 1) == 1;
    mem_break    = ($urandom_range(0, 9) == 0);
    mem_syscall  = ($urandom_range(0, 9) == 0);
    mem_eret     = ($urandom_range(0, 5) == 0);
    mem_reserve  = ($urandom_range(0, 9) == 0);
    mem_overflow = ($urandom_range(0, 9) == 0);
    mem_adel_if  = ($urandom_range(0, 9) == 0);
    mem_adel     = ($urandom_range(0, 9) == 0);
    mem_ades     = ($urandom_range(0, 9) == 0);
    mem_bad_addr = $urandom();
    hw_int       = ($urandom_range(0, 2) == 0) ? 6'($urandom()) : 6'b0;
    cp0_we       = ($urandom_range(0, 2) == 0);
    cp0_waddr    = pick_reg();
    cp0_raddr    = pick_reg();
    cp0_wdata    = $urandom();
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic run_cycle();
    #1;
    model_decide();
    check("flush",    32'(flush),    32'(e_flush));
    check("new_pc",   new_pc,        e_pc);
    check("exc_code", 32'(exc_code), 32'(e_code));
    check("status",   status_o,      m_status);
    check("cause",    cause_o,       m_cause);
    check("epc",      epc_o,         m_epc);
    check("rdata",    cp0_rdata,     model_read(cp0_raddr));
    model_step();
    @(negedge clk);
  endtask

  // Asynchronous reset: state must be back at reset values without a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    cp0_raddr = 5'd9;
    #1;
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause",  cause_o,  32'h0);
    check("rst_epc",    epc_o,    32'h0);
    check("rst_count",  cp0_rdata, 32'h0);
    check("rst_flush",  32'(flush), 32'h0);
    check("rst_newpc",  new_pc,   32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // syscall, not in a delay slot
    idle(); mem_valid = 1; mem_syscall = 1; mem_pc = 32'h8000_0010;
    #1;
    check("sys_flush", 32'(flush), 32'h1);
    check("sys_newpc", new_pc, 32'hBFC0_0380);
    check("sys_code", 32'(exc_code), 32'h08);
    run_cycle();
    check("sys_epc", epc_o, 32'h8000_0010);
    check("sys_exl", 32'(status_o[1]), 32'h1);

    // clear EXL through mtc0 Status
    idle(); cp0_we = 1; cp0_waddr = 5'd12; cp0_wdata = 32'h0;
    run_cycle();

    // break beats overflow; delay slot rewinds EPC
    idle(); mem_valid = 1; mem_break = 1; mem_overflow = 1; mem_in_delay = 1;
    mem_pc = 32'h8000_0024;
    #1;
    check("bp_code", 32'(exc_code), 32'h09);
    run_cycle();
    check("bp_epc", epc_o, 32'h8000_0020);
    check("bp_bd", 32'(cause_o[31]), 32'h1);

    // load EPC then eret
    idle(); cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h8000_0100;
    run_cycle();
    idle(); mem_valid = 1; mem_eret = 1;
    #1;
    check("eret_flush", 32'(flush), 32'h1);
    check("eret_newpc", new_pc, 32'h8000_0100);
    check("eret_code", 32'(exc_code), 32'h1f);
    run_cycle();
    check("eret_exl", 32'(status_o[1]), 32'h0);

    // enable IM[2]/IE, raise hw_int[0], then interrupt beats a same-cycle mtc0
    idle(); cp0_we = 1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0401; hw_int = 6'b000001;
    run_cycle();
    idle(); hw_int = 6'b000001; mem_valid = 1; mem_pc = 32'h8000_0040;
    cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
    #1;
    check("int_flush", 32'(flush), 32'h1);
    check("int_code", 32'(exc_code), 32'h00);
    run_cycle();
    check("int_epc", epc_o, 32'h8000_0040);

    // bubble in MEM: flags ignored
    idle(); mem_syscall = 1; mem_ades = 1; mem_bad_addr = 32'h1234_5678;
    #1;
    check("bubble_flush", 32'(flush), 32'h0);
    run_cycle();
    check("bubble_status", status_o, 32'h0040_0403);

    // Count wrap
    idle(); cp0_we = 1; cp0_waddr = 5'd9; cp0_wdata = 32'hFFFF_FFFF; cp0_raddr = 5'd9;
    run_cycle();
    for (int i = 0; i < 4; i++) begin
      idle(); cp0_raddr = 5'd9;
      run_cycle();
    end

`ifdef CP0_TIMER_INT_EN
    begin
      logic seen;
      seen = 1'b0;
      idle(); cp0_we = 1; cp0_waddr = 5'd11; cp0_wdata = 32'd4; run_cycle();
      idle(); cp0_we = 1; cp0_waddr = 5'd9;  cp0_wdata = 32'd0; run_cycle();
      idle(); cp0_we = 1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_8001; run_cycle();
      for (int i = 0; i < 30 && !seen; i++) begin
        idle(); mem_valid = 1; mem_pc = 32'h8000_0200;
        #1;
        if (flush && exc_code == 5'h00) seen = 1'b1;
        run_cycle();
      end
      check("timer_irq", 32'(seen), 32'h1);
      idle(); cp0_we = 1; cp0_waddr = 5'd11; cp0_wdata = 32'd0; run_cycle();
      idle(); run_cycle();
      idle(); run_cycle();
      check("timer_ip7_clr", 32'(cause_o[15]), 32'h0);
    end
`endif

    // randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      if ($urandom_range(0, 199) == 0) do_reset();
      else run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_exception.md
# cp0_exception

Coprocessor-0 register file and precise-exception controller for the five-stage MIPS pipeline. Consumes the per-instruction exception flags produced in decode (break, syscall, eret, reserved-instruction) and carried to MEM, plus overflow, address-error and interrupt sources. Decides on at most one exception per cycle, raises the pipeline flush, supplies the redirect PC, and maintains Status, Cause, EPC, BadVAddr, Count and Compare.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380: redirect PC for every exception except eret.
- HW_INT_W, 6: number of external hardware interrupt lines.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_valid  input  1  MEM-stage instruction is valid; when low, no exception is detected.
- mem_pc  input  32  PC of the MEM-stage instruction.
- mem_in_delay  input  1  MEM instruction sits in a branch delay slot.
- mem_break, mem_syscall, mem_eret, mem_reserve  input  1 each  flags from decode.
- mem_overflow  input  1  ALU signed overflow.
- mem_adel_if, mem_adel, mem_ades  input  1 each  fetch, load and store address errors.
- mem_bad_addr  input  32  faulting data address (load/store).
- hw_int  input  HW_INT_W  level-sensitive external interrupts.
- cp0_we  input  1  mtc0 write enable.
- cp0_waddr, cp0_raddr  input  5  register numbers.
- cp0_wdata  input  32  mtc0 data.
- cp0_rdata  output  32  mfc0 data; combinational from current register state.
- flush  output  1  exception or eret taken this cycle.
- new_pc  output  32  redirect target, valid while flush=1.
- exc_code  output  5  ExcCode of the taken exception; 5'h1f for eret; 0 otherwise.
- status_o, cause_o, epc_o  output  32 each  current register values.

## Operation
- Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); reads of other numbers return 0.
- Interrupt pending: Status.IE=1, Status.EXL=0, and (Cause.IP[7:2] & Status.IM[7:2]) != 0. Cause.IP[7:2] is sampled each cycle from hw_int; IP[7] is additionally ORed with the timer flag.
- Priority, highest first, gated by mem_valid: interrupt (0x00), AdEL fetch (0x04, BadVAddr=mem_pc), RI (0x0a), Sys (0x08), Bp (0x09), Ov (0x0c), AdEL data (0x04, BadVAddr=mem_bad_addr), AdES (0x05, BadVAddr=mem_bad_addr), eret.
- Exception taken: flush=1, new_pc=EXC_VECTOR, exc_code set. On the next edge: Status.EXL←1; Cause.ExcCode←code; Cause.BD←mem_in_delay; EPC←mem_pc−4 if mem_in_delay else mem_pc, written only when Status.EXL was 0; BadVAddr written only for address errors.
- eret taken: flush=1, new_pc=EPC; Status.EXL←0 at next edge.
- mtc0: writable fields are Status.IM, Status.EXL, Status.IE, Cause.IP[1:0], EPC, Count, Compare; all others are read-only. A write is suppressed whenever flush=1 in the same cycle.
- Count increments by 1 every second cycle (internal toggle bit, reset 0) and wraps 32'hFFFF_FFFF→0. An mtc0 write to Count wins over the increment.

## Timing
- Detection, flush, new_pc and exc_code are combinational in the MEM cycle; register updates appear one edge later.
- Reset values: Status=32'h0040_0000 (BEV=1, IE=0, EXL=0), Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, toggle=0, timer flag=0; flush=0, new_pc=0, exc_code=0.
- Reset asserted mid-exception aborts the update; all registers return to reset values immediately.
- Simultaneous exception flags: only the highest priority is reported.
- mem_valid=0 with flags set: no flush and no state change (a bubble in MEM).
- Simultaneous mtc0 and exception: exception wins; no part of the write is applied.

## Configuration
- CP0_TIMER_INT_EN defined: the timer flag is set at the edge where Count==Compare and Compare!=0, held until an mtc0 write to Compare clears it, and drives Cause.IP[7].
- Undefined: the timer flag is tied to 0; Count and Compare remain readable and writable; Cause.IP[7] follows hw_int[5] only.

## Test plan
- Reset, then read Status/Cause/EPC -> 32'h0040_0000, 0, 0; flush=0.
- mem_valid=1, mem_syscall=1, mem_pc=32'h8000_0010, mem_in_delay=0 -> flush=1, new_pc=32'hBFC0_0380, exc_code=0x08; next cycle EPC=32'h8000_0010, Status.EXL=1.
- mem_break=1 and mem_overflow=1 together, mem_in_delay=1, mem_pc=32'h8000_0024 -> exc_code=0x09, EPC=32'h8000_0020, Cause.BD=1.
- eret while EPC=32'h8000_0100, EXL=1 -> flush=1, new_pc=32'h8000_0100, exc_code=5'h1f; EXL=0 next cycle.
- mtc0 Status=32'h0000_0401, hw_int[0]=1, valid instruction in MEM -> interrupt taken, exc_code=0x00, mtc0 in the same cycle dropped.
- With CP0_TIMER_INT_EN: Compare=4, Count=0, Status=32'h0000_8001 -> interrupt taken about 8 cycles later; after mtc0 to Compare, Cause.IP[7]=0.
